// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin search used by the 4-way mux arbiter.
package mux_arb_pkg;

   localparam int N_REQ = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set request wins.
   // The loop runs backwards so the nearest index is the last one written.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
      pick_t      p;
      logic [1:0] i;
      p = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         i = ptr + 2'(k);
         if (req[i]) begin
            p.found = 1'b1;
            p.idx   = i;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux4to1.sv
// Single-bit 4:1 multiplexer shared by the four requesters.
module mux4to1 (
   input  logic [3:0] d_i,
   input  logic [1:0] s_i,
   output logic       y_o
);

   assign y_o = d_i[s_i];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux; each tenure is capped at MAX_HOLD
// cycles and the selected bit is registered onto Y with a valid flag.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [3:0]       D,
   output logic [3:0]       gnt,
   output logic [1:0]       S,
   output logic             Y,
   output logic             valid,
   output logic             busy,
   output state_e           dbg_state,
   output logic [CNT_W-1:0] dbg_cnt
);

   state_e           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       s_q, s_d;
   logic             y_q, valid_q;
   logic             mux_y;
   logic             tenure_end;
   pick_t            pick_idle, pick_next;

   mux4to1 u_mux (
      .d_i (D),
      .s_i (s_q),
      .y_o (mux_y)
   );

   // In IDLE the search starts at ptr; at tenure end it starts just past the owner.
   assign pick_idle  = rr_pick(req, ptr_q);
   assign pick_next  = rr_pick(req, s_q + 2'd1);
   assign tenure_end = !req[s_q] || (cnt_q == CNT_W'(MAX_HOLD));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      s_d     = s_q;
      case (state_q)
         IDLE: begin
            if (pick_idle.found) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << pick_idle.idx;
               s_d     = pick_idle.idx;
               cnt_d   = CNT_W'(1);
            end
         end
         GRANT: begin
            if (!tenure_end) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               ptr_d = s_q + 2'd1;
               if (pick_next.found) begin
                  gnt_d = 4'b0001 << pick_next.idx;
                  s_d   = pick_next.idx;
                  cnt_d = CNT_W'(1);
               end else begin
                  // S keeps its last value so Y still reflects the final owner.
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
                  cnt_d   = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         cnt_q   <= '0;
         gnt_q   <= 4'b0000;
         s_q     <= 2'd0;
         y_q     <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         s_q     <= s_d;
         valid_q <= (state_q == GRANT);
         if (state_q == GRANT) begin
            y_q <= mux_y;
         end
      end
   end

   assign gnt       = gnt_q;
   assign S         = s_q;
   assign Y         = y_q;
   assign valid     = valid_q;
   assign busy      = (state_q == GRANT);
   assign dbg_state = state_q;
   assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized stimulus against a cycle-level reference model of the arbiter.
module tb_mux4_rr_arbiter;
   import mux_arb_pkg::*;

   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 4;
   localparam int EW       = 4 + 2 + 1 + 1 + 1 + CNT_W;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       req;
   logic [3:0]       D;
   logic [3:0]       gnt;
   logic [1:0]       S;
   logic             Y;
   logic             valid;
   logic             busy;
   state_e           dbg_state;
   logic [CNT_W-1:0] dbg_cnt;

   logic [EW-1:0] exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            gcount[4];

   // reference model state
   logic             m_busy;
   logic [1:0]       m_ptr;
   logic [CNT_W-1:0] m_cnt;
   logic [3:0]       m_gnt;
   logic [1:0]       m_s;
   logic             m_y;
   logic             m_valid;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .D         (D),
      .gnt       (gnt),
      .S         (S),
      .Y         (Y),
      .valid     (valid),
      .busy      (busy),
      .dbg_state (dbg_state),
      .dbg_cnt   (dbg_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_search(input logic [3:0] rq, input logic [1:0] start,
                               output logic found, output logic [1:0] win);
      found = 1'b0;
      win   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (!found && rq[(int'(start) + k) % 4]) begin
            found = 1'b1;
            win   = 2'((int'(start) + k) % 4);
         end
      end
   endtask

   task automatic model_edge(input logic r, input logic [3:0] rq, input logic [3:0] d);
      logic       f;
      logic [1:0] w;
      if (r) begin
         m_busy = 0; m_ptr = 0; m_cnt = 0; m_gnt = 0; m_s = 0; m_y = 0; m_valid = 0;
      end else begin
         if (m_busy) m_y = d[m_s];
         m_valid = m_busy;
         if (!m_busy) begin
            model_search(rq, m_ptr, f, w);
            if (f) begin
               m_busy = 1; m_gnt = 4'b0001 << w; m_s = w; m_cnt = 1;
            end
         end else if (rq[m_s] && m_cnt < CNT_W'(MAX_HOLD)) begin
            m_cnt = m_cnt + 1;
         end else begin
            m_ptr = m_s + 2'd1;
            model_search(rq, m_ptr, f, w);
            if (f) begin
               m_gnt = 4'b0001 << w; m_s = w; m_cnt = 1;
            end else begin
               m_busy = 0; m_gnt = 0; m_cnt = 0;
            end
         end
      end
   endtask

   task automatic check_out();
      logic [EW-1:0]    e;
      logic [3:0]       eg;
      logic [1:0]       es;
      logic             ey, ev, eb;
      logic [CNT_W-1:0] ec;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = exp_q.pop_front();
      {eg, es, ey, ev, eb, ec} = e;
      chk("gnt",   8'(gnt),       8'(eg));
      chk("S",     8'(S),         8'(es));
      chk("Y",     8'(Y),         8'(ey));
      chk("valid", 8'(valid),     8'(ev));
      chk("busy",  8'(busy),      8'(eb));
      chk("state", 8'(dbg_state), 8'(eb));
      chk("cnt",   8'(dbg_cnt),   8'(ec));
      chk("cnt_le_max", 8'(dbg_cnt <= CNT_W'(MAX_HOLD)), 8'd1);
   endtask

   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] d);
      rst = r;
      req = rq;
      D   = d;
      model_edge(r, rq, d);
      exp_q.push_back({m_gnt, m_s, m_y, m_valid, m_busy, m_cnt});
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      D   = 4'b0000;
      m_busy = 0; m_ptr = 0; m_cnt = 0; m_gnt = 0; m_s = 0; m_y = 0; m_valid = 0;
      @(negedge clk);

      // reset with all requests pending, then first grant goes to 0
      step(1'b1, 4'b1111, 4'b1111);
      step(1'b1, 4'b1111, 4'b1111);
      step(1'b0, 4'b1111, 4'b0001);
      chk("first_grant", 8'(gnt), 8'h01);
      step(1'b0, 4'b1111, 4'b0001);

      // single requester 2 for three cycles
      step(1'b1, 4'b0000, 4'b0000);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 4'b0100);
      step(1'b0, 4'b0000, 4'b0100);
      chk("single_valid_tail", 8'(valid), 8'h01);
      step(1'b0, 4'b0000, 4'b0000);
      chk("single_idle_Y_hold", 8'(Y), 8'h01);

      // hold limit with two requesters
      step(1'b1, 4'b0000, 4'b0000);
      for (int i = 0; i < 12; i++) step(1'b0, 4'b0011, 4'($urandom_range(0, 15)));
      chk("hold_regrant0", 8'(gnt), 8'h01);

      // fairness over 32 cycles with all requesting
      step(1'b1, 4'b0000, 4'b0000);
      for (int i = 0; i < 4; i++) gcount[i] = 0;
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 4'b1111, 4'($urandom_range(0, 15)));
         for (int j = 0; j < 4; j++) if (gnt[j] === 1'b1) gcount[j]++;
      end
      for (int j = 0; j < 4; j++) chk($sformatf("fair_total%0d", j), 8'(gcount[j]), 8'd8);

      // early release by owner 3 wraps the pointer to 0
      step(1'b1, 4'b0000, 4'b0000);
      step(1'b0, 4'b1000, 4'b1000);
      step(1'b0, 4'b1001, 4'b1000);
      step(1'b0, 4'b0001, 4'b0001);
      chk("wrap_gnt", 8'(gnt), 8'h01);
      chk("wrap_cnt", 8'(dbg_cnt), 8'h01);

      // reset in the middle of a tenure of requester 2
      step(1'b1, 4'b0000, 4'b0000);
      step(1'b0, 4'b0100, 4'b0100);
      step(1'b0, 4'b0100, 4'b0100);
      step(1'b1, 4'b0100, 4'b0100);
      chk("midrst_gnt", 8'(gnt), 8'h00);
      chk("midrst_valid", 8'(valid), 8'h00);
      step(1'b0, 4'b0101, 4'b0101);
      chk("midrst_regrant0", 8'(gnt), 8'h01);

      // randomized traffic with occasional resets
      for (int i = 0; i < 60; i++)
         step(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
